// File: rtl/vga_sprite_compositor.sv
// VGA timing generator compositing NUM_SPRITES rectangles over a fetched map background.
// Pixel for counter (h,v) reaches the outputs two clocks later; sprite changes commit at frame start.
module vga_sprite_compositor #(
   parameter int H_DISPLAY   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_PULSE     = 96,
   parameter int H_BACK      = 48,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_PULSE     = 2,
   parameter int V_BACK      = 33,
   parameter int NUM_SPRITES = 5,
   parameter int COLOR_W     = 3,
   parameter bit SYNC_POL    = 1'b0,
   localparam int IW         = $clog2(NUM_SPRITES),
   localparam int CW         = 3 * COLOR_W
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   WR_EN,
   input  logic [IW-1:0]          WR_IDX,
   input  logic [9:0]             WR_X,
   input  logic [9:0]             WR_Y,
   input  logic [5:0]             WR_W,
   input  logic [5:0]             WR_H,
   input  logic [CW-1:0]          WR_RGB,
   input  logic                   WR_ON,
   output logic [9:0]             BG_X,
   output logic [9:0]             BG_Y,
   input  logic [CW-1:0]          BG_RGB,
   output logic                   VGA_HS,
   output logic                   VGA_VS,
   output logic [COLOR_W-1:0]     VGA_R,
   output logic [COLOR_W-1:0]     VGA_G,
   output logic [COLOR_W-1:0]     VGA_B,
   output logic                   FRAME_START,
   output logic [NUM_SPRITES-1:0] COLLISION
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_PULSE + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_PULSE + V_BACK;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
   localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_PULSE);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_PULSE);

   typedef struct packed {
      logic          on;
      logic [9:0]    x;
      logic [9:0]    y;
      logic [5:0]    w;
      logic [5:0]    h;
      logic [CW-1:0] rgb;
   } spr_t;

   spr_t shadow_q [NUM_SPRITES];
   spr_t shadow_d [NUM_SPRITES];
   spr_t active_q [NUM_SPRITES];
   spr_t active_d [NUM_SPRITES];

   logic [9:0]             h_q, h_d, v_q, v_d;
   logic [NUM_SPRITES-1:0] acc_q, acc_d, coll_q, coll_d;
   logic                   disp1_q, disp1_d, hs1_q, hs1_d, vs1_q, vs1_d, hit1_q, hit1_d;
   logic [CW-1:0]          spr1_q, spr1_d, rgb2_q, rgb2_d;
   logic                   hs2_q, hs2_d, vs2_q, vs2_d;
   logic                   frame_end;
   logic [NUM_SPRITES-1:0] hit;

   // S0: raster counters, sprite hit test and shadow/active bookkeeping
   always_comb begin
      frame_end = (h_q == H_LAST) && (v_q == V_LAST);
      h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
      v_d = v_q;
      if (h_q == H_LAST) v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

      // 11-bit compares so x+w / y+h never wrap into the left or top edge
      hit = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         hit[i] = active_q[i].on
            && ({1'b0, h_q} >= {1'b0, active_q[i].x})
            && ({1'b0, h_q} <  ({1'b0, active_q[i].x} + {5'b0, active_q[i].w}))
            && ({1'b0, v_q} >= {1'b0, active_q[i].y})
            && ({1'b0, v_q} <  ({1'b0, active_q[i].y} + {5'b0, active_q[i].h}));
      end

      disp1_d = (h_q < H_DISP) && (v_q < V_DISP);
      hs1_d   = (h_q >= HS_START) && (h_q < HS_END);
      vs1_d   = (v_q >= VS_START) && (v_q < VS_END);
      hit1_d  = 1'b0;
      spr1_d  = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (hit[i]) begin
            hit1_d = 1'b1;
            spr1_d = active_q[i].rgb;
         end
      end

      // Commit copies the pre-write shadow, so a same-cycle write waits a frame
      shadow_d = shadow_q;
      active_d = active_q;
      if (frame_end) active_d = shadow_q;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (WR_EN && (WR_IDX == IW'(i))) shadow_d[i] = {WR_ON, WR_X, WR_Y, WR_W, WR_H, WR_RGB};
      end

      acc_d  = acc_q;
      coll_d = coll_q;
      if (disp1_d && hit[0]) acc_d = acc_q | hit;
      acc_d[0] = 1'b0;
      if (frame_end) begin
         coll_d = acc_d;
         acc_d  = '0;
      end
   end

   // S1 -> S2: BG_RGB for this pixel arrives one cycle after its coordinate
   always_comb begin
      rgb2_d = '0;
      if (disp1_q) rgb2_d = hit1_q ? spr1_q : BG_RGB;
      hs2_d = hs1_q ? SYNC_POL : ~SYNC_POL;
      vs2_d = vs1_q ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         h_q     <= '0;
         v_q     <= '0;
         acc_q   <= '0;
         coll_q  <= '0;
         disp1_q <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         hit1_q  <= 1'b0;
         spr1_q  <= '0;
         rgb2_q  <= '0;
         hs2_q   <= ~SYNC_POL;
         vs2_q   <= ~SYNC_POL;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         h_q      <= h_d;
         v_q      <= v_d;
         acc_q    <= acc_d;
         coll_q   <= coll_d;
         disp1_q  <= disp1_d;
         hs1_q    <= hs1_d;
         vs1_q    <= vs1_d;
         hit1_q   <= hit1_d;
         spr1_q   <= spr1_d;
         rgb2_q   <= rgb2_d;
         hs2_q    <= hs2_d;
         vs2_q    <= vs2_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end

   assign BG_X        = h_q;
   assign BG_Y        = v_q;
   assign VGA_HS      = hs2_q;
   assign VGA_VS      = vs2_q;
   assign VGA_R       = rgb2_q[CW-1 -: COLOR_W];
   assign VGA_G       = rgb2_q[2*COLOR_W-1 -: COLOR_W];
   assign VGA_B       = rgb2_q[COLOR_W-1:0];
   assign FRAME_START = RST_N && (h_q == 10'd0) && (v_q == 10'd0);
   assign COLLISION   = coll_q;

endmodule
